core_sequencer: RTL and testbench

- Per-core control FSM; drives the shared `core_state` bus seen by fetcher, decoder, ALUs, LSUs and per-thread PC/NZP units.
- Sequences each instruction through FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE.
- Waits on fetcher and LSU handshakes, owns the core's shared `current_pc`, and flags thread divergence.
- Sits between dispatcher start/done signalling and the core's per-thread datapath.

---
 rtl/core_sequencer_if.sv | 38 +++
 rtl/core_sequencer.sv | 89 ++++++++
 tb/tb_core_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: handshake/status bundle between a core's sequencer and its datapath.
// CORE_SEQ_PERF_CNT_EN adds the instruction and stall counters.
interface core_sequencer_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
);
  logic start;
  logic [THREADS_PER_BLOCK-1:0] thread_enable;
  logic [2:0] fetcher_state;
  logic decoded_ret;
  logic [2*THREADS_PER_BLOCK-1:0] lsu_state;
  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc;
  logic [2:0] core_state;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc;
  logic done;
  logic diverged;
`ifdef CORE_SEQ_PERF_CNT_EN
  logic [15:0] instr_count;
  logic [15:0] stall_count;
  modport master (
    output start, thread_enable, fetcher_state, decoded_ret, lsu_state, next_pc,
    input core_state, current_pc, done, diverged, instr_count, stall_count
  );
  modport slave (
    input start, thread_enable, fetcher_state, decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, done, diverged, instr_count, stall_count
  );
`else
  modport master (
    output start, thread_enable, fetcher_state, decoded_ret, lsu_state, next_pc,
    input core_state, current_pc, done, diverged
  );
  modport slave (
    input start, thread_enable, fetcher_state, decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, done, diverged
  );
`endif
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: per-core FETCH..UPDATE control FSM owning the shared PC and divergence flag.
// CORE_SEQ_PERF_CNT_EN adds saturating instr_count/stall_count outputs.
module core_sequencer #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input logic clk,
  input logic reset,
  core_sequencer_if.slave bus
);
  localparam int T = THREADS_PER_BLOCK;
  localparam int W = PROGRAM_MEM_ADDR_BITS;
  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] FETCH = 3'b001;
  localparam logic [2:0] DECODE = 3'b010;
  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] WAIT = 3'b100;
  localparam logic [2:0] EXECUTE = 3'b101;
  localparam logic [2:0] UPDATE = 3'b110;
  localparam logic [2:0] DONE = 3'b111;
  localparam logic [2:0] FETCHED = 3'b010;
  logic [2:0] state, state_nxt;
  logic [W-1:0] pc, sel_pc;
  logic done, diverged, busy, mismatch;
  always_comb begin
    sel_pc = '0;
    for (int i = T - 1; i >= 0; i--)
      if (bus.thread_enable[i]) sel_pc = bus.next_pc[i*W +: W];
  end
  // LSU codes 01/10 differ in their two bits, so XOR marks a lane still in flight
  always_comb begin
    busy = 1'b0;
    mismatch = 1'b0;
    for (int i = 0; i < T; i++) begin
      busy = busy | (bus.thread_enable[i] & (bus.lsu_state[2*i+1] ^ bus.lsu_state[2*i]));
      mismatch = mismatch | (bus.thread_enable[i] & (bus.next_pc[i*W +: W] != sel_pc));
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = |bus.thread_enable ? FETCH : DONE;
      FETCH: if (bus.fetcher_state == FETCHED) state_nxt = DECODE;
      DECODE: state_nxt = REQUEST;
      REQUEST: state_nxt = WAIT;
      WAIT: if (!busy) state_nxt = EXECUTE;
      EXECUTE: state_nxt = UPDATE;
      UPDATE: state_nxt = bus.decoded_ret ? DONE : FETCH;
      default: state_nxt = state;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      done <= 1'b0;
      diverged <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= state_nxt == DONE;
      if (state == UPDATE && !bus.decoded_ret) begin
        pc <= sel_pc;
        diverged <= diverged | mismatch;
      end
    end
  assign bus.core_state = state;
  assign bus.current_pc = pc;
  assign bus.done = done;
  assign bus.diverged = diverged;
`ifdef CORE_SEQ_PERF_CNT_EN
  logic [2:0] prev_state;
  logic [15:0] instr_count, stall_count;
  logic stall;
  // a repeat of FETCH or WAIT means the previous cycle already spent its free first cycle
  assign stall = (state == FETCH || state == WAIT) && prev_state == state;
  always_ff @(posedge clk)
    if (reset) begin
      prev_state <= IDLE;
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      prev_state <= state;
      if (state == UPDATE && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  assign bus.instr_count = instr_count;
  assign bus.stall_count = stall_count;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized scoreboard bench; an instruction-level model predicts every cycle's outputs.
module tb_core_sequencer;
  localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010, S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT = 3'b100, S_EXECUTE = 3'b101, S_UPDATE = 3'b110, S_DONE = 3'b111;
  typedef struct {
    logic [2:0] s;
    logic [7:0] pc;
    logic d;
    logic dv;
    logic [15:0] ic;
    logic [15:0] sc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  core_sequencer_if #(.THREADS_PER_BLOCK(4), .PROGRAM_MEM_ADDR_BITS(8)) bus ();
  core_sequencer #(.THREADS_PER_BLOCK(4), .PROGRAM_MEM_ADDR_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  exp_t exq[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  logic [3:0] te = 4'b0000;
  logic [7:0] m_pc = '0;
  logic m_div = 1'b0;
  logic [15:0] m_ic = '0, m_sc = '0;

  function automatic void chk(string n, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (exq.size() != 0) begin
      cur = exq.pop_front();
      chk("core_state", 16'(bus.core_state), 16'(cur.s));
      chk("current_pc", 16'(bus.current_pc), 16'(cur.pc));
      chk("done", 16'(bus.done), 16'(cur.d));
      chk("diverged", 16'(bus.diverged), 16'(cur.dv));
`ifdef CORE_SEQ_PERF_CNT_EN
      chk("instr_count", bus.instr_count, cur.ic);
      chk("stall_count", bus.stall_count, cur.sc);
`endif
    end
  end

  function automatic logic [2:0] not_fetched();
    logic [2:0] v;
    v = 3'($urandom_range(0, 6));
    return v >= 3'd2 ? v + 3'd1 : v;
  endfunction

  task automatic tick(input logic [2:0] s);
    exq.push_back('{s, m_pc, s == S_DONE, m_div, m_ic, m_sc});
    @(negedge clk);
  endtask

  task automatic noise();
    bus.start = 1'($urandom);
    bus.fetcher_state = 3'($urandom);
    bus.decoded_ret = 1'($urandom);
    bus.lsu_state = 8'($urandom);
    bus.next_pc = $urandom;
  endtask

  task automatic do_reset();
    noise();
    reset = 1'b1;
    m_pc = '0;
    m_div = 1'b0;
    m_ic = '0;
    m_sc = '0;
    tick(S_IDLE);
    reset = 1'b0;
  endtask

  task automatic begin_block(input logic [3:0] en, input int idle);
    te = en;
    bus.thread_enable = en;
    for (int k = 0; k < idle; k++) begin
      noise();
      bus.start = 1'b0;
      tick(S_IDLE);
    end
    noise();
    bus.start = 1'b1;
    tick(en == 4'b0000 ? S_DONE : S_FETCH);
  endtask

  task automatic fetch_to_wait(input int f);
    for (int j = 1; j <= f; j++) begin
      noise();
      bus.fetcher_state = (j == f) ? 3'b010 : not_fetched();
      if (j > 1) m_sc++;
      tick(j == f ? S_DECODE : S_FETCH);
    end
    noise();
    tick(S_REQUEST);
    noise();
    tick(S_WAIT);
  endtask

  // bl holds per-lane busy cycle counts (4 bits each); WAIT ends once every enabled lane is idle/done
  task automatic run_instr(input int f, input logic [15:0] bl, input logic [31:0] np, input logic ret);
    int nw;
    logic [7:0] sel;
    bit found;
    fetch_to_wait(f);
    nw = 1;
    for (int i = 0; i < 4; i++)
      if (te[i] && int'(bl[4*i +: 4]) + 1 > nw) nw = int'(bl[4*i +: 4]) + 1;
    for (int t = 0; t < nw; t++) begin
      noise();
      for (int i = 0; i < 4; i++)
        bus.lsu_state[2*i +: 2] = !te[i] ? 2'b01 :
          (t < int'(bl[4*i +: 4])) ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) :
          ($urandom_range(0, 1) ? 2'b00 : 2'b11);
      if (t > 0) m_sc++;
      tick(t == nw - 1 ? S_EXECUTE : S_WAIT);
    end
    noise();
    tick(S_UPDATE);
    noise();
    bus.decoded_ret = ret;
    bus.next_pc = np;
    m_ic++;
    if (!ret) begin
      found = 0;
      sel = '0;
      for (int i = 0; i < 4; i++)
        if (te[i] && !found) begin
          sel = np[8*i +: 8];
          found = 1;
        end
      m_pc = sel;
      for (int i = 0; i < 4; i++)
        if (te[i] && np[8*i +: 8] != sel) m_div = 1'b1;
    end
    tick(ret ? S_DONE : S_FETCH);
  endtask

  task automatic hold_done(input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      tick(S_DONE);
    end
  endtask

  initial begin
    logic [7:0] r;
    int n;
    bus.thread_enable = 4'b0000;
    noise();
    @(negedge clk);
    do_reset();
    do_reset();
    // ADD then RET, all lanes uniform
    begin_block(4'b1111, 2);
    run_instr(1, 16'h0000, 32'h01010101, 1'b0);
    run_instr(1, 16'h0000, 32'h01010101, 1'b1);
    hold_done(3);
    // LDR with lane0 busy 4 cycles then done, disabled lane1 stuck requesting
    do_reset();
    begin_block(4'b0101, 1);
    run_instr(1, 16'h0004, 32'h22222222, 1'b0);
    run_instr(2, 16'h0000, 32'h22222222, 1'b1);
    // branch divergence persists through uniform instructions
    do_reset();
    begin_block(4'b0110, 0);
    run_instr(1, 16'h0000, 32'h550308AA, 1'b0);
    run_instr(1, 16'h0000, 32'h10101010, 1'b0);
    run_instr(1, 16'h0000, 32'h10101010, 1'b1);
    hold_done(2);
    // empty block goes straight to DONE
    do_reset();
    begin_block(4'b0000, 1);
    hold_done(3);
    // reset while lanes are waiting
    do_reset();
    begin_block(4'b1111, 0);
    fetch_to_wait(1);
    for (int k = 0; k < 2; k++) begin
      noise();
      bus.lsu_state = 8'b10101010;
      tick(S_WAIT);
    end
    bus.lsu_state = 8'b10101010;
    do_reset();
    // three instructions each with a 2-cycle fetch
    begin_block(4'b1111, 0);
    run_instr(2, 16'h0000, 32'h04040404, 1'b0);
    run_instr(2, 16'h0000, 32'h05050505, 1'b0);
    run_instr(2, 16'h0000, 32'h06060606, 1'b1);
    hold_done(1);
    // randomized blocks
    for (int b = 0; b < 25; b++) begin
      do_reset();
      begin_block(($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)), $urandom_range(0, 2));
      if (te != 4'b0000) begin
        n = $urandom_range(0, 4);
        for (int k = 0; k < n; k++)
          run_instr($urandom_range(1, 4), 16'($urandom) & 16'h3333,
                    ($urandom_range(0, 1) != 0) ? $urandom : {4{8'(k + 1)}}, 1'b0);
        r = 8'($urandom);
        run_instr($urandom_range(1, 3), 16'($urandom) & 16'h3333, {4{r}}, 1'b1);
      end
      hold_done($urandom_range(1, 3));
    end
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
